periph_bus_fabric: RTL and testbench
====================================

Name: periph_bus_fabric

Overview:
Parametrised memory-mapped interconnect between the FemtoRV32 core port and N peripheral slaves.
- Decodes the address into one-hot chip-selects.
- Issues read/write strobes and waits on per-slave ready, driving the core's mem_rbusy/mem_wbusy.
- Registers the selected slave's read data.
- Optionally aborts stalled transactions with a bus-error response.
- Supersedes the fixed decoder and read-mux inside the SoC top.

Parameters:
- N_SLAVES, 6, number of slaves; slave 0 is the default (RAM) target.
- SEL_HI, 31, top address bit of the decode field.
- SEL_LO, 16, bottom address bit of the decode field.
- BASE_SEL, 16'h0040, decode value for slave 1; slave i>=1 decodes at BASE_SEL+i-1.
- ZERO_WAIT_MASK, 6'b000001, slaves in the mask are treated as ready one cycle after the strobe; their s_ready is ignored.
- TIMEOUT, 255, wait cycles before abort (used only with BUS_TIMEOUT_EN).
- ERR_DATA, 32'h66666666, read data returned on an aborted or undecoded read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- m_addr  in  32  core address.
- m_wdata  in  32  core write data; passed through unchanged to s_wdata.
- m_wmask  in  4  byte write mask; any bit set means a write request.
- m_rstrb  in  1  read request pulse.
- m_rdata  out  32  registered read data.
- m_rbusy  out  1  read in progress.
- m_wbusy  out  1  write in progress.
- s_cs  out  N_SLAVES  one-hot chip-select.
- s_rd  out  1  read strobe.
- s_wr  out  1  write strobe.
- s_wmask  out  4  byte mask gated by the active request.
- s_wdata  out  32  write data.
- s_rdata  in  32*N_SLAVES  flattened slave read data; slave i occupies bits [32i+31:32i].
- s_ready  in  N_SLAVES  per-slave completion.
- err_clr  in  1  clears the sticky error.
- err  out  1  sticky bus-error flag.
- err_addr  out  32  address of the first aborted transaction.

Behaviour:
- Reset values: all outputs 0, except m_rdata = 0 and s_cs = 0; state IDLE.
- Reset mid-transaction aborts immediately. No data is returned and the error flag is not set.
- States: IDLE and WAIT.
- IDLE, request at cycle T:
  - s_cs is decoded combinationally from m_addr[SEL_HI:SEL_LO].
  - s_rd = m_rstrb and s_wr = |m_wmask, high for cycle T only.
  - m_addr, the select and the request type are latched; state moves to WAIT at T+1.
- Read and write asserted in the same cycle: the write wins and s_rd stays 0.
- WAIT:
  - s_cs is held from the latch and strobes are 0.
  - m_rbusy (read) or m_wbusy (write) is high.
  - Requests arriving in WAIT are ignored; the core must not issue them.
- Completion: at the first WAIT cycle where the selected slave is ready (s_ready[sel]=1, or sel is in ZERO_WAIT_MASK):
  - a read latches s_rdata[sel] into m_rdata;
  - the state returns to IDLE;
  - busy is deasserted on the next cycle.
- Minimum latency is 1 WAIT cycle; busy is high for exactly 1 cycle on zero-wait slaves.
- Undecoded addresses: none exist, since the default is slave 0. A decode value >= BASE_SEL+N_SLAVES-1 also selects slave 0.
- m_rdata holds its last value between reads.
- err_clr has priority over a same-cycle error set: the clear wins and the event is dropped.

Optional Feature:
Macro BUS_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter resets on entry to WAIT.
  - When the counter reaches TIMEOUT with the slave still not ready, the fabric aborts: a read sets m_rdata = ERR_DATA; the state returns to IDLE.
  - On abort, err is set. err_addr latches the address only if err was already 0.
- Undefined:
  - The fabric waits indefinitely.
  - err and err_addr are tied to 0 and err_clr is ignored.

Decomposition:
- Package bus_fabric_pkg holds:
  - the state encoding (IDLE = 1'b0, WAIT = 1'b1);
  - the default ERR_DATA and BASE_SEL constants;
  - the default slave index constants (RAM = 0, UART = 1, GPIO = 2, MULT = 3, DIV = 4, BCD = 5).
- Sub-module bus_timeout_counter holds the counter, the compare and the sticky err/err_addr. It is instantiated only under BUS_TIMEOUT_EN.

Test Plan:
1. Read 0x00000010 (RAM, zero-wait), s_rdata[0] = 0xCAFEF00D:
   - s_cs = 000001 and s_rd high at T; m_rbusy high at T+1 only; m_rdata = 0xCAFEF00D at T+2.
2. Write 0x00430004 (DIV) with wmask 4'hF; s_ready[4] asserted at T+4:
   - s_cs = 010000 and s_wr pulse at T; m_wbusy high T+1..T+4, low at T+5.
3. Read 0x00400000 (UART) with s_ready[1] never asserted, BUS_TIMEOUT_EN, TIMEOUT = 8:
   - abort after 8 WAIT cycles; m_rdata = 0x66666666; err = 1; err_addr = 0x00400000.
   - A second timeout leaves err_addr unchanged; err_clr pulse returns err to 0.
4. Same-cycle m_rstrb = 1 and wmask = 4'h3 at 0x00420000:
   - s_wr = 1 and s_rd = 0; s_wmask = 4'h3; m_wbusy asserted, m_rbusy stays 0.
5. rst asserted during WAIT of a slave-3 read:
   - s_cs, m_rbusy and m_wbusy go to 0 asynchronously; state IDLE; err = 0.
   - The next RAM read completes normally.
6. Address 0x00FF0000:
   - selects slave 0 (s_cs = 000001) and completes zero-wait.

Source files
------------

// File: rtl/bus_fabric_pkg.sv
// rtl/bus_fabric_pkg.sv - shared state encoding, default constants and slave indices for the peripheral bus fabric
package bus_fabric_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'h66666666;
  localparam logic [15:0] DEF_BASE_SEL = 16'h0040;

  localparam int SLV_RAM  = 0;
  localparam int SLV_UART = 1;
  localparam int SLV_GPIO = 2;
  localparam int SLV_MULT = 3;
  localparam int SLV_DIV  = 4;
  localparam int SLV_BCD  = 5;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - wait-cycle counter, abort compare and sticky bus-error capture
module bus_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        waiting,
  input  logic        ready,
  input  logic [31:0] addr,
  input  logic        err_clr,
  output logic        abort,
  output logic        err,
  output logic [31:0] err_addr
);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of WAIT cycles already elapsed, so the abort fires in the TIMEOUT-th one
  assign abort = waiting && !ready && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (waiting && !ready) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (abort) begin
      err <= 1'b1;
      if (!err) err_addr <= addr;
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// rtl/periph_bus_fabric.sv - address decode, strobe/ready handshake and read-data capture between core and N slaves
// Optional stalled-transaction abort enabled by defining BUS_TIMEOUT_EN.
module periph_bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                          N_SLAVES       = 6,
  parameter int                          SEL_HI         = 31,
  parameter int                          SEL_LO         = 16,
  parameter logic [SEL_HI-SEL_LO:0]      BASE_SEL       = DEF_BASE_SEL[SEL_HI-SEL_LO:0],
  parameter logic [N_SLAVES-1:0]         ZERO_WAIT_MASK = N_SLAVES'(1),
  parameter int                          TIMEOUT        = 255,
  parameter logic [31:0]                 ERR_DATA       = DEF_ERR_DATA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wmask,
  input  logic                     m_rstrb,
  output logic [31:0]              m_rdata,
  output logic                     m_rbusy,
  output logic                     m_wbusy,
  output logic [N_SLAVES-1:0]      s_cs,
  output logic                     s_rd,
  output logic                     s_wr,
  output logic [3:0]               s_wmask,
  output logic [31:0]              s_wdata,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic                     err_clr,
  output logic                     err,
  output logic [31:0]              err_addr
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_t           state, state_n;
  logic [IDX_W-1:0] dec_idx, sel_q;
  logic             is_rd_q;
  logic             req_rd, req_wr, start, sel_ready, done, abort;
  logic [SEL_W-1:0] sel_field;
  logic [31:0]      rdata_arr [N_SLAVES];

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdata
    assign rdata_arr[i] = s_rdata[32*i +: 32];
  end

  assign sel_field = m_addr[SEL_HI:SEL_LO];
  assign req_wr    = |m_wmask;
  assign req_rd    = m_rstrb && !req_wr;
  assign start     = (state == IDLE) && (req_rd || req_wr);
  assign sel_ready = s_ready[sel_q] || ZERO_WAIT_MASK[sel_q];
  assign done      = (state == WAIT) && sel_ready;
  assign s_wdata   = m_wdata;

  // Anything outside the slave window, above or below, falls through to slave 0
  always_comb begin
    dec_idx = '0;
    for (int i = 1; i < N_SLAVES; i++) begin
      if (sel_field == BASE_SEL + SEL_W'(i - 1)) dec_idx = IDX_W'(i);
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 256) ? 8 : 16;
  logic [31:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        addr_q <= '0;
    else if (start) addr_q <= m_addr;
  end

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .waiting  (state == WAIT),
    .ready    (sel_ready),
    .addr     (addr_q),
    .err_clr  (err_clr),
    .abort    (abort),
    .err      (err),
    .err_addr (err_addr)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{err_clr, m_addr} ^ (TIMEOUT != 0);
  assign abort     = 1'b0;
  assign err       = 1'b0;
  assign err_addr  = '0;
`endif

  always_comb begin
    state_n = state;
    s_cs    = '0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    s_wmask = '0;
    m_rbusy = 1'b0;
    m_wbusy = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          s_cs    = N_SLAVES'(1) << dec_idx;
          s_rd    = req_rd;
          s_wr    = req_wr;
          s_wmask = m_wmask;
          state_n = WAIT;
        end
      end
      WAIT: begin
        s_cs    = N_SLAVES'(1) << sel_q;
        m_rbusy = is_rd_q;
        m_wbusy = !is_rd_q;
        if (done || abort) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      is_rd_q <= 1'b0;
      m_rdata <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        sel_q   <= dec_idx;
        is_rd_q <= req_rd;
      end
      if (done && is_rd_q)       m_rdata <= rdata_arr[sel_q];
      else if (abort && is_rd_q) m_rdata <= ERR_DATA;
    end
  end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// tb/tb_periph_bus_fabric.sv - table-driven and sequence checks for periph_bus_fabric
module tb_periph_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  logic        m_rstrb;
  logic [31:0] m_rdata;
  logic        m_rbusy, m_wbusy;
  logic [5:0]  s_cs;
  logic        s_rd, s_wr;
  logic [3:0]  s_wmask;
  logic [31:0] s_wdata;
  logic [191:0] s_rdata;
  logic [5:0]  s_ready;
  logic        err_clr, err;
  logic [31:0] err_addr;

  int tests = 0;
  int fails = 0;

  periph_bus_fabric #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr), .s_wmask(s_wmask), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic        rstrb;
    int          ready_at;
    logic [5:0]  exp_cs;
    logic        exp_rd;
    logic        exp_wr;
    logic [3:0]  exp_wmask;
    int          exp_busy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] wmask, input logic rstrb);
    @(negedge clk);
    m_addr  = addr;
    m_wmask = wmask;
    m_rstrb = rstrb;
    m_wdata = addr ^ 32'h5A5A0000;
    #1;
  endtask

  task automatic wait_done(input logic [5:0] cs, input int ready_at, input int budget,
                           input logic want_rd, output int busy_cnt, output int wrong);
    busy_cnt = 0;
    wrong    = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      m_rstrb = 1'b0;
      m_wmask = 4'h0;
      s_ready = (k >= ready_at) ? cs : 6'b0;
      #1;
      if (!(m_rbusy || m_wbusy)) break;
      busy_cnt++;
      if (want_rd ? m_wbusy : m_rbusy) wrong++;
      if (s_rd || s_wr || (s_cs != cs)) wrong++;
    end
    s_ready = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int busy_cnt, wrong;
    logic want_rd;
    want_rd = v.rstrb && (v.wmask == 4'h0);
    issue(v.addr, v.wmask, v.rstrb);
    chk({tag, " s_cs"}, s_cs, v.exp_cs);
    chk({tag, " s_rd"}, s_rd, v.exp_rd);
    chk({tag, " s_wr"}, s_wr, v.exp_wr);
    chk({tag, " s_wmask"}, s_wmask, v.exp_wmask);
    chk({tag, " s_wdata"}, s_wdata, v.addr ^ 32'h5A5A0000);
    wait_done(v.exp_cs, v.ready_at, 40, want_rd, busy_cnt, wrong);
    chk({tag, " busy_cycles"}, busy_cnt, v.exp_busy);
    chk({tag, " wait_phase"}, wrong, 0);
    chk({tag, " m_rdata"}, m_rdata, v.exp_rdata);
  endtask

  initial begin
    int busy_cnt, wrong;
    vecs[0]  = '{32'h00000010, 4'h0, 1'b1, 99, 6'b000001, 1'b1, 1'b0, 4'h0, 1, 32'hCAFEF00D};
    vecs[1]  = '{32'h00430004, 4'hF, 1'b0, 4,  6'b010000, 1'b0, 1'b1, 4'hF, 4, 32'hCAFEF00D};
    vecs[2]  = '{32'h00420000, 4'h3, 1'b1, 1,  6'b001000, 1'b0, 1'b1, 4'h3, 1, 32'hCAFEF00D};
    vecs[3]  = '{32'h00400000, 4'h0, 1'b1, 2,  6'b000010, 1'b1, 1'b0, 4'h0, 2, 32'h11110001};
    vecs[4]  = '{32'h00FF0000, 4'h0, 1'b1, 99, 6'b000001, 1'b1, 1'b0, 4'h0, 1, 32'hCAFEF00D};
    vecs[5]  = '{32'h00410000, 4'h0, 1'b1, 1,  6'b000100, 1'b1, 1'b0, 4'h0, 1, 32'h22220002};
    vecs[6]  = '{32'h0044ABCD, 4'h0, 1'b1, 3,  6'b100000, 1'b1, 1'b0, 4'h0, 3, 32'h55550005};
    vecs[7]  = '{32'h00450000, 4'h0, 1'b1, 99, 6'b000001, 1'b1, 1'b0, 4'h0, 1, 32'hCAFEF00D};
    vecs[8]  = '{32'h00420010, 4'h0, 1'b1, 1,  6'b001000, 1'b1, 1'b0, 4'h0, 1, 32'h33330003};
    vecs[9]  = '{32'h003F0000, 4'h0, 1'b1, 99, 6'b000001, 1'b1, 1'b0, 4'h0, 1, 32'hCAFEF00D};
    vecs[10] = '{32'h00000020, 4'h5, 1'b0, 99, 6'b000001, 1'b0, 1'b1, 4'h5, 1, 32'hCAFEF00D};

    s_rdata = {32'h55550005, 32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001, 32'hCAFEF00D};
    rst = 1'b1; m_addr = 32'h00430000; m_wdata = '0; m_wmask = 4'h0; m_rstrb = 1'b0;
    s_ready = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset s_cs", s_cs, 6'b0);
    chk("reset m_rdata", m_rdata, 32'h0);
    chk("reset busy", {m_rbusy, m_wbusy, s_rd, s_wr}, 4'h0);
    chk("reset err", err, 1'b0);
    chk("reset err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a slave-3 read
    issue(32'h00420000, 4'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      m_rstrb = 1'b0;
    end
    #1;
    chk("midrst pre rbusy", m_rbusy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst s_cs", s_cs, 6'b0);
    chk("midrst busy", {m_rbusy, m_wbusy}, 2'b00);
    chk("midrst err", err, 1'b0);
    chk("midrst m_rdata", m_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "post_rst");

`ifdef BUS_TIMEOUT_EN
    issue(32'h00400000, 4'h0, 1'b1);
    wait_done(6'b000010, 99, 20, 1'b1, busy_cnt, wrong);
    chk("to1 busy_cycles", busy_cnt, 8);
    chk("to1 m_rdata", m_rdata, 32'h66666666);
    chk("to1 err", err, 1'b1);
    chk("to1 err_addr", err_addr, 32'h00400000);
    issue(32'h00410000, 4'h0, 1'b1);
    wait_done(6'b000100, 99, 20, 1'b1, busy_cnt, wrong);
    chk("to2 busy_cycles", busy_cnt, 8);
    chk("to2 err", err, 1'b1);
    chk("to2 err_addr", err_addr, 32'h00400000);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("to err_clr", err, 1'b0);
`else
    issue(32'h00400000, 4'h0, 1'b1);
    wait_done(6'b000010, 31, 40, 1'b1, busy_cnt, wrong);
    chk("nto busy_cycles", busy_cnt, 31);
    chk("nto wait_phase", wrong, 0);
    chk("nto m_rdata", m_rdata, 32'h11110001);
    chk("nto err", err, 1'b0);
    chk("nto err_addr", err_addr, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
